// File: rtl/regfile_sb.sv
// regfile_sb: N-read/1-write register file with per-register pending-write scoreboard and optional bypass
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic [AW-1:0]          rd,
  input  logic [WIDTH-1:0]       data,
  input  logic                   reserve_en,
  input  logic [AW-1:0]          reserve_rd,
  input  logic                   flush,
  input  logic [NREAD*AW-1:0]    rin,
  output logic [NREAD*WIDTH-1:0] rs,
  output logic [NREAD-1:0]       rs_busy,
  output logic                   any_busy
);
  localparam logic [AW:0] DEP = DEPTH[AW:0];
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] pending, pend_nxt;
  logic wr_ok, rs_ok;
  assign wr_ok = write_en && ({1'b0, rd} < DEP) && !(ZR && rd == '0);
  assign rs_ok = reserve_en && ({1'b0, reserve_rd} < DEP) && !(ZR && reserve_rd == '0);
  // priority: flush > reserve > write-clear
  always_comb begin
    pend_nxt = pending;
    if (wr_ok) pend_nxt[rd] = 1'b0;
    if (rs_ok) pend_nxt[reserve_rd] = 1'b1;
    if (flush) pend_nxt = '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      pending <= pend_nxt;
      if (wr_ok) rf[rd] <= data;
    end
  end
  assign any_busy = |pending;
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic ok, hit;
    assign a   = rin[k*AW +: AW];
    assign ok  = ({1'b0, a} < DEP) && !(ZR && a == '0);
    assign hit = BP && wr_ok && rd == a;
    assign rs[k*WIDTH +: WIDTH] = (!reset || !ok) ? '0 : hit ? data : rf[a];
    assign rs_busy[k] = reset && ok && !hit && pending[a];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of default, no-bypass and resized register files
module tb_regfile_sb;
  logic clk = 0, reset = 0;
  logic we = 0, res_en = 0, flush = 0;
  logic [4:0] rd = 0, res_rd = 0;
  logic [31:0] data = 0;
  logic [9:0] rin = 0;
  logic [63:0] rs_a, rs_b;
  logic [1:0] busy_a, busy_b;
  logic any_a, any_b;
  logic we2 = 0;
  logic [4:0] rd2 = 0;
  logic [15:0] data2 = 0;
  logic [14:0] rin2 = 0;
  logic [47:0] rs2;
  logic [2:0] busy2;
  logic any2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  regfile_sb u_a (.clk(clk), .reset(reset), .write_en(we), .rd(rd), .data(data),
    .reserve_en(res_en), .reserve_rd(res_rd), .flush(flush), .rin(rin),
    .rs(rs_a), .rs_busy(busy_a), .any_busy(any_a));
  regfile_sb #(.BYPASS(0)) u_b (.clk(clk), .reset(reset), .write_en(we), .rd(rd), .data(data),
    .reserve_en(res_en), .reserve_rd(res_rd), .flush(flush), .rin(rin),
    .rs(rs_b), .rs_busy(busy_b), .any_busy(any_b));
  regfile_sb #(.WIDTH(16), .DEPTH(24), .NREAD(3), .ZERO_REG(0)) u_c (.clk(clk), .reset(reset),
    .write_en(we2), .rd(rd2), .data(data2), .reserve_en(1'b0), .reserve_rd(5'd0), .flush(1'b0),
    .rin(rin2), .rs(rs2), .rs_busy(busy2), .any_busy(any2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_rs_a", rs_a[31:0], 0);
    chk("rst_busy_a", {30'd0, busy_a}, 0);
    chk("rst_any_a", {31'd0, any_a}, 0);
    #5 reset = 1;
    tick();
    we = 1; rd = 0; data = 32'hDEADBEEF; rin = {5'd0, 5'd0};
    #1 chk("zero_bypass", rs_a[31:0], 0);
    tick();
    we = 0;
    #1 chk("zero_after", rs_a[31:0], 0);
    we = 1; rd = 5; data = 32'h12345678; rin = {5'd5, 5'd5};
    #1 chk("byp_rs", rs_a[31:0], 32'h12345678);
    chk("byp_busy", {31'd0, busy_a[0]}, 0);
    chk("nobyp_old", rs_b[31:0], 0);
    tick();
    we = 0;
    #1 chk("nobyp_new", rs_b[31:0], 32'h12345678);
    chk("byp_port1", rs_a[63:32], 32'h12345678);
    res_en = 1; res_rd = 7; rin = {5'd7, 5'd7};
    #1 chk("res_same_cyc", {31'd0, busy_a[0]}, 0);
    tick();
    res_en = 0;
    #1 chk("res_busy_a", {30'd0, busy_a}, 2'b11);
    chk("res_any_a", {31'd0, any_a}, 1);
    chk("res_busy_b", {31'd0, busy_b[0]}, 1);
    we = 1; rd = 7; data = 32'hA5;
    #1 chk("wb_rs_a", rs_a[31:0], 32'hA5);
    chk("wb_busy_a", {31'd0, busy_a[0]}, 0);
    chk("wb_any_same", {31'd0, any_a}, 1);
    chk("wb_busy_b", {31'd0, busy_b[0]}, 1);
    chk("wb_rs_b", rs_b[31:0], 0);
    tick();
    we = 0;
    #1 chk("wb_any_next", {31'd0, any_a}, 0);
    chk("wb_rs_b_next", rs_b[31:0], 32'hA5);
    chk("wb_busy_b_next", {31'd0, busy_b[0]}, 0);
    we = 1; rd = 3; data = 32'h11; res_en = 1; res_rd = 3; rin = {5'd3, 5'd3};
    #1 chk("wr_res_byp", rs_a[31:0], 32'h11);
    chk("wr_res_byp_busy", {31'd0, busy_a[0]}, 0);
    tick();
    we = 0; res_en = 0;
    #1 chk("wr_res_data", rs_a[31:0], 32'h11);
    chk("wr_res_pend", {31'd0, busy_a[0]}, 1);
    chk("wr_res_any", {31'd0, any_a}, 1);
    flush = 1; res_en = 1; res_rd = 4; rin = {5'd3, 5'd4};
    tick();
    flush = 0; res_en = 0;
    #1 chk("flush_busy", {30'd0, busy_a}, 0);
    chk("flush_any", {31'd0, any_a}, 0);
    res_en = 1; res_rd = 9; rin = {5'd7, 5'd5};
    tick();
    res_en = 0;
    #1 chk("pre_rst_any", {31'd0, any_a}, 1);
    chk("pre_rst_rs", rs_a[31:0], 32'h12345678);
    reset = 0;
    #1 chk("async_rs0", rs_a[31:0], 0);
    chk("async_rs1", rs_a[63:32], 0);
    chk("async_any", {31'd0, any_a}, 0);
    tick();
    reset = 1;
    #1 chk("post_rst_rs", rs_a[31:0], 0);
    we2 = 1; rd2 = 0; data2 = 16'hBEEF; rin2 = {5'd0, 5'd0, 5'd0};
    #1 chk("c_r0_byp", {16'd0, rs2[15:0]}, 32'hBEEF);
    tick();
    we2 = 0;
    #1 chk("c_r0_reg", {16'd0, rs2[15:0]}, 32'hBEEF);
    we2 = 1; rd2 = 25; data2 = 16'h1234; rin2 = {5'd0, 5'd25, 5'd0};
    #1 chk("c_oob_byp", {16'd0, rs2[31:16]}, 0);
    tick();
    we2 = 0;
    #1 chk("c_oob_reg", {16'd0, rs2[31:16]}, 0);
    we2 = 1; rd2 = 23; data2 = 16'hCAFE;
    tick();
    we2 = 0; rin2 = {5'd23, 5'd23, 5'd23};
    #1 chk("c_p0", {16'd0, rs2[15:0]}, 32'hCAFE);
    chk("c_p1", {16'd0, rs2[31:16]}, 32'hCAFE);
    chk("c_p2", {16'd0, rs2[47:32]}, 32'hCAFE);
    chk("c_busy", {29'd0, busy2}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the frisc core, with N read ports, one write port, an optional hardwired-zero register and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard. Decode reserves a destination register. Writeback clears the reservation when the data lands.
- Read ports report whether their operand is still in flight, so issue logic can stall.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers (≥2; need not be a power of two).
- NREAD, 2, number of read ports (≥1).
- ZERO_REG, 1, 1 = register 0 always reads 0; writes and reserves to it are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded combinationally to matching read ports.
- AW, $clog2(DEPTH), index width (derived; not overridden by users).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- write_en  input  1  write data into register rd this cycle.
- rd  input  AW  write index.
- data  input  WIDTH  write data.
- reserve_en  input  1  mark register reserve_rd pending.
- reserve_rd  input  AW  reservation index.
- flush  input  1  clear all pending bits (pipeline squash).
- rin  input  NREAD*AW  read indices; port k uses bits [k*AW +: AW].
- rs  output  NREAD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH].
- rs_busy  output  NREAD  1 = operand on port k is pending (not yet written).
- any_busy  output  1  OR of all pending bits.

Behaviour:
- Reset (reset==0, asynchronous)
  - All registers are cleared to 0 and all pending bits are cleared.
  - While reset is held: rs reads 0, rs_busy=0, any_busy=0.
  - Deassertion takes effect at the next posedge.
- Reads are combinational: rs[k] = rf[rin[k]].
  - If ZERO_REG and rin[k]==0: rs[k]=0 and rs_busy[k]=0.
  - If rin[k] ≥ DEPTH: rs[k]=0 and rs_busy[k]=0.
- Write (posedge, write_en=1)
  - rf[rd] <= data.
  - Ignored if rd ≥ DEPTH, or if ZERO_REG and rd==0.
  - Clears pending[rd].
- Reserve (posedge, reserve_en=1): sets pending[reserve_rd]. Same ignore rules as write.
- Simultaneous write and reserve of the same index: reserve wins, and pending ends at 1 (a newer producer is in flight). The data is still written.
- Simultaneous write and reserve of different indices: both take effect.
- Flush (posedge, flush=1)
  - All pending bits cleared.
  - A write in the same cycle still updates data.
  - A reserve in the same cycle is dropped; flush has priority.
- rs_busy[k] = pending[rin[k]], with the exception below.
- Bypass (BYPASS=1)
  - If write_en=1, the write is legal, and rd==rin[k] in the same cycle: rs[k]=data and rs_busy[k]=0.
  - This holds even if pending[rd] is set. A same-cycle reserve of that index does not make rs_busy[k]=1 until the next cycle.
- BYPASS=0: reads return the registered value only. The written value is visible the cycle after the write. rs_busy[k] reflects the pending bit as it was before the edge.
- Multiple read ports may address the same register; each returns an identical result.
- any_busy is the registered OR of pending bits. It is unaffected by bypass.
- Latency:
  - Write-to-read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Reserve-to-busy: 1 cycle.
  - Write-to-not-busy: 0 cycles with bypass, otherwise 1 cycle.
- No internal FSM beyond the pending bit vector. The pending bit vector is a DEPTH-bit state register with the priority rules above: reset > flush > reserve > write-clear.

Test Plan:
- Reset and zero register
  - Drive reset=0 mid-run with registers holding nonzero values → all rs=0, any_busy=0 immediately, without waiting for a clock edge.
  - Write rd=0, data=32'hDEADBEEF, then read rin=0 → 0.
- Bypass, default parameters
  - write_en=1, rd=5, data=32'h12345678, rin port0=5 → rs port0=32'h12345678 in the same cycle, rs_busy[0]=0.
  - With BYPASS=0, the same stimulus → rs port0 returns the old value, then 32'h12345678 next cycle.
- Scoreboard
  - reserve rd=7 → next cycle rs_busy=1 on a port reading 7, any_busy=1.
  - write rd=7, data=32'hA5 → same-cycle rs_busy=0 and rs=32'hA5; next cycle any_busy=0.
- Simultaneous events
  - Same cycle: write rd=3 data=32'h11, reserve rd=3 → rf[3]=32'h11 and pending[3]=1 afterwards.
  - Same cycle: flush plus reserve rd=4 → pending[4]=0.
- Parameter sweep with WIDTH=16, DEPTH=24, NREAD=3, ZERO_REG=0
  - Write rd=0, data=16'hBEEF → reads 16'hBEEF.
  - Write rd=25 → ignored; rin=25 returns 0.
  - Three ports reading the same register match.
